// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 streaming demultiplexer: channel ids,
// packet-lock FSM states and default widths.
package demux_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register with a saturating handshake counter.
// The slot may be refilled in the same cycle it drains.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              slot_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              drain;

    assign drain      = vld_p1 && out_ready;
    assign slot_ready = !vld_p1 || out_ready;

    // Stage p1: registered slot and delivered-beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            if (load) begin
                data_p1 <= load_data;
            end
            vld_p1 <= load || (vld_p1 && !out_ready);
            if (drain) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign cnt       = cnt_p1;

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 streaming demultiplexer with independent per-channel output slots.
// Optional packet locking is enabled by defining DEMUX_PKT_LOCK_EN.
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic dst;
    logic ready0;
    logic ready1;
    logic accept;
    logic load0;
    logic load1;

`ifdef DEMUX_PKT_LOCK_EN
    lock_state_t state;
    lock_state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Destination decode is kept apart from next-state so accept never feeds back into dst
    always_comb begin
        dst = in_sel;
        case (state)
            LOCK0:   dst = CH0;
            LOCK1:   dst = CH1;
            default: dst = in_sel;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_nxt = (in_sel == CH1) ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (accept && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    logic unused_last;
    assign unused_last = in_last;
    assign dst         = in_sel;
`endif

    assign in_ready = (dst == CH1) ? ready1 : ready0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (dst == CH0);
    assign load1    = accept && (dst == CH1);

    demux_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load0),
        .load_data  (in_data),
        .slot_ready (ready0),
        .out_data   (out0_data),
        .out_valid  (out0_valid),
        .out_ready  (out0_ready),
        .cnt        (cnt0)
    );

    demux_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1),
        .load_data  (in_data),
        .slot_ready (ready1),
        .out_data   (out1_data),
        .out_valid  (out1_valid),
        .out_ready  (out1_ready),
        .cnt        (cnt1)
    );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream: per-channel scoreboard queues plus
// scenario tasks. Packet-lock scenario runs when DEMUX_PKT_LOCK_EN is defined.
module tb_demux1to2_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_sel = 1'b0;
    logic       in_last = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready = 1'b1;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b1;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       mv0 = 1'b0;
    logic       mv1 = 1'b0;
    logic [7:0] mc0 = 8'h00;
    logic [7:0] mc1 = 8'h00;
    int         ms = 0;

    always #5 clk = ~clk;

    demux1to2_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    function automatic logic model_dst();
        if (ms == 1) return 1'b0;
        if (ms == 2) return 1'b1;
        return in_sel;
    endfunction

    task automatic scoreboard();
        logic       d;
        logic       acc;
        logic       exp_rdy;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                mv0 = 1'b0;
                mv1 = 1'b0;
                mc0 = 8'h00;
                mc1 = 8'h00;
                ms  = 0;
            end else begin
                d = model_dst();
                exp_rdy = d ? (!mv1 || out1_ready) : (!mv0 || out0_ready);
                checks++;
                if (in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, in_ready, exp_rdy);
                end
                checks++;
                if (out0_valid !== mv0 || out1_valid !== mv1) begin
                    errors++;
                    $display("FAIL sb_valid t=%0t got %b%b exp %b%b", $time, out1_valid, out0_valid, mv1, mv0);
                end
                checks++;
                if (cnt0 !== mc0 || cnt1 !== mc1) begin
                    errors++;
                    $display("FAIL sb_cnt t=%0t got %0d/%0d exp %0d/%0d", $time, cnt0, cnt1, mc0, mc1);
                end
                if (out0_valid && out0_ready) begin
                    checks++;
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL sb_out0_spurious t=%0t got %h exp none", $time, out0_data);
                    end else begin
                        e = q0.pop_front();
                        if (out0_data !== e) begin
                            errors++;
                            $display("FAIL sb_out0_data t=%0t got %h exp %h", $time, out0_data, e);
                        end
                    end
                end
                if (out1_valid && out1_ready) begin
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL sb_out1_spurious t=%0t got %h exp none", $time, out1_data);
                    end else begin
                        e = q1.pop_front();
                        if (out1_data !== e) begin
                            errors++;
                            $display("FAIL sb_out1_data t=%0t got %h exp %h", $time, out1_data, e);
                        end
                    end
                end
                if (mv0 && out0_ready) mc0 = (mc0 == 8'hFF) ? mc0 : mc0 + 8'd1;
                if (mv1 && out1_ready) mc1 = (mc1 == 8'hFF) ? mc1 : mc1 + 8'd1;
                acc = in_valid && in_ready;
                if (acc) begin
                    if (d) q1.push_back(in_data);
                    else   q0.push_back(in_data);
                end
                mv0 = (mv0 && !out0_ready) || (acc && !d);
                mv1 = (mv1 && !out1_ready) || (acc && d);
`ifdef DEMUX_PKT_LOCK_EN
                if (acc) begin
                    if (ms == 0 && !in_last) ms = in_sel ? 2 : 1;
                    else if (ms != 0 && in_last) ms = 0;
                end
`endif
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic l);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data %h: in_ready stayed 0, expected acceptance", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_sel   = 1'b0;
        #2;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl got v0=%b v1=%b rdy=%b exp 0 0 1", out0_valid, out1_valid, in_ready);
        end
        checks++;
        if (cnt0 !== 8'h00 || cnt1 !== 8'h00 || out0_data !== 8'h00 || out1_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got cnt %0d/%0d data %h/%h exp zeros", cnt0, cnt1, out0_data, out1_data);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h11 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_beat got v0=%b d0=%h v1=%b exp 1 11 0", out0_valid, out0_data, out1_valid);
        end
        in_data = 8'h22;
        in_sel  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h22 || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL second_beat got v1=%b d1=%h v0=%b exp 1 22 0", out1_valid, out1_data, out0_valid);
        end
        idle(1);
        checks++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL first_counts got %0d/%0d exp 1/1", cnt0, cnt1);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] d;
        c0 = cnt0;
        c1 = cnt1;
        for (int i = 0; i < 8; i++) begin
            d = 8'h40 + 8'(i);
            send(d, d[0], 1'b1);
        end
        idle(2);
        checks++;
        if (cnt0 !== c0 + 8'd4 || cnt1 !== c1 + 8'd4) begin
            errors++;
            $display("FAIL alternate_counts got %0d/%0d exp %0d/%0d", cnt0, cnt1, c0 + 8'd4, c1 + 8'd4);
        end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0;
        send(8'h77, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_sel   = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b exp 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h77 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got v0=%b d0=%h rdy=%b exp 1 77 0", out0_valid, out0_data, in_ready);
        end
        in_data = 8'h5A;
        in_sel  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready got %b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h5A || out0_data !== 8'h77) begin
            errors++;
            $display("FAIL bp_other_path got v1=%b d1=%h d0=%h exp 1 5a 77", out1_valid, out1_data, out0_data);
        end
        out0_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_stream();
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_last    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i * 7);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_bubble beat %0d in_ready got %b exp 1", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(2);
        checks++;
        if (cnt1 !== 8'hFF) begin
            errors++;
            $display("FAIL stream_saturate cnt1 got %0d exp 255", cnt1);
        end
        send(8'hEE, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (cnt1 !== 8'hFF) begin
            errors++;
            $display("FAIL stream_no_wrap cnt1 got %0d exp 255", cnt1);
        end
    endtask

    task automatic test_mid_reset();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(8'h91, 1'b0, 1'b1);
        send(8'h92, 1'b1, 1'b1);
        checks++;
        if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_full got v0=%b v1=%b exp 1 1", out0_valid, out1_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 8'h00 || cnt1 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async got v=%b%b cnt %0d/%0d exp 00 0/0", out1_valid, out0_valid, cnt0, cnt1);
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 8'h00 || cnt1 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_after got v=%b%b cnt %0d/%0d exp 00 0/0", out1_valid, out0_valid, cnt0, cnt1);
        end
    endtask

`ifdef DEMUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(8'h31, 1'b1, 1'b0);
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h31) begin
            errors++;
            $display("FAIL lock_beat1 got v1=%b d1=%h exp 1 31", out1_valid, out1_data);
        end
        send(8'h32, 1'b0, 1'b0);
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h32 || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_beat2 got v1=%b d1=%h v0=%b exp 1 32 0", out1_valid, out1_data, out0_valid);
        end
        send(8'h33, 1'b0, 1'b1);
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h33 || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_beat3 got v1=%b d1=%h v0=%b exp 1 33 0", out1_valid, out1_data, out0_valid);
        end
        send(8'h34, 1'b0, 1'b1);
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h34) begin
            errors++;
            $display("FAIL lock_release got v0=%b d0=%h exp 1 34", out0_valid, out0_data);
        end
        idle(2);
    endtask
`endif

    initial begin
        fork
            scoreboard();
        join_none
        test_reset();
        test_alternate();
        test_backpressure();
        test_stream();
`ifdef DEMUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        test_mid_reset();
        idle(3);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drained pending %0d/%0d exp 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
